pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter DRAIN_CYCLES, default 2: cycles the pipeline drains between IRQ acceptance and exception entry (legal 1..7).
REQ-002 Parameter CNT_W, default 16: width of the stall performance counter.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 id_rs, id_rt  in  5 each  source registers of the instruction in ID.
REQ-006 ex_rt  in  5  destination Rt of the instruction in EX; ex_mem_read  in  1  EX instruction is a load.
REQ-007 jump_id  in  1  J/JAL/JR/JALR resolved in ID; branch_taken_ex  in  1  branch resolved taken in EX.
REQ-008 mem_busy  in  1  data memory not ready this cycle.
REQ-009 irq  in  1  external interrupt request, level; pc31  in  1  ID-stage PC bit 31 (kernel mode, IRQ masked).
REQ-010 pc_write, if_id_write, id_ex_write, ex_mem_write  out  1 each  register enables.
REQ-011 if_id_flush, id_ex_flush, mem_wb_bubble  out  1 each  insert NOP into that register.
REQ-012 epc_capture  out  1  save ID-stage PC to EPC; exc_enter  out  1  load PC with exception vector.
REQ-013 stall_cnt  out  CNT_W  cycles with pc_write=0 since reset, saturating.

Function
REQ-014 FSM states RUN, MEM_WAIT, IRQ_DRAIN, IRQ_ENTER; all control outputs combinational from state and inputs.
REQ-015 Defaults: all *_write=1, all flush/bubble/epc_capture/exc_enter=0.
REQ-016 load_use = ex_mem_read & ex_rt!=0 & (ex_rt==id_rs | ex_rt==id_rt).
REQ-017 RUN priority, highest first: mem_busy, branch_taken_ex, irq accept, load_use, jump_id.
REQ-018 RUN & mem_busy: all *_write=0, mem_wb_bubble=1; next state MEM_WAIT.
REQ-019 MEM_WAIT: same outputs while mem_busy=1; when mem_busy=0, defaults and next RUN; no other event is acted on in that cycle.
REQ-020 RUN & branch_taken_ex: if_id_flush=1, id_ex_flush=1, pc_write=1 (target loaded); load_use and jump_id ignored.
REQ-021 IRQ accept = RUN & irq & ~pc31 & ~mem_busy & ~branch_taken_ex: epc_capture=1, if_id_flush=1, id_ex_flush=1, pc_write=0; drain counter loads DRAIN_CYCLES-1; next IRQ_DRAIN.
REQ-022 IRQ_DRAIN: pc_write=0, if_id_flush=1, id_ex_flush=1; counter decrements each cycle mem_busy=0; mem_busy=1 applies REQ-018 freeze and holds the counter; at counter 0 with mem_busy=0, next IRQ_ENTER.
REQ-023 IRQ_ENTER (exactly one cycle): exc_enter=1, pc_write=1, if_id_flush=1; next RUN; mem_busy here freezes and holds IRQ_ENTER.
REQ-024 RUN & load_use: pc_write=0, if_id_write=0, id_ex_flush=1; exactly one bubble per load-use pair.
REQ-025 RUN & jump_id (no higher event): if_id_flush=1.
REQ-026 irq ignored outside RUN; a still-asserted irq after IRQ_ENTER is re-evaluated only under pc31=0.
REQ-027 stall_cnt increments by 1 every cycle pc_write=0, saturates at all-ones, never wraps.

Reset
REQ-028 reset=1 forces state RUN, drain counter 0, stall_cnt 0 immediately, including mid-drain or mid-wait.
REQ-029 During reset, outputs equal RUN defaults with all inputs ignored; first edge after deassertion evaluates normally.

Structure
REQ-030 State encoding and vector constant belong in the shared CPU package; DRAIN_CYCLES default lives there too.
REQ-031 One sub-module, hazard_detect: purely combinational load_use (REQ-016).

Verification
REQ-032 ex_mem_read=1, ex_rt=5, id_rs=5 in RUN -> one cycle pc_write=0, if_id_write=0, id_ex_flush=1; stall_cnt 0->1.
REQ-033 ex_rt=0, id_rs=0, ex_mem_read=1 -> no stall, outputs at defaults.
REQ-034 branch_taken_ex=1 with load_use=1 and jump_id=1 -> if_id_flush=1, id_ex_flush=1, pc_write=1, if_id_write=1.
REQ-035 irq=1, pc31=0, DRAIN_CYCLES=2 -> epc_capture at t, IRQ_DRAIN t+1, exc_enter=1 at t+2; with mem_busy=1 at t+1 for 3 cycles, exc_enter moves to t+5.
REQ-036 mem_busy=1 for 4 cycles in RUN -> all *_write=0 4 cycles, stall_cnt +4; pc31=1 with irq=1 -> no epc_capture.
REQ-037 reset pulse in IRQ_DRAIN -> immediate RUN outputs, stall_cnt=0; stall_cnt forced to saturation stays all-ones.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared CPU pipeline-control definitions: FSM states, exception vector,
// drain default.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_MEM_WAIT  = 2'd1,
    ST_IRQ_DRAIN = 2'd2,
    ST_IRQ_ENTER = 2'd3
  } pipe_state_t;

  localparam int          DRAIN_CYCLES_DEF = 2;
  localparam logic [31:0] EXC_VECTOR       = 32'h8000_0080;
  localparam int          DRAIN_W          = 3;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard detection: a load in EX feeding a source register in ID.
module hazard_detect (
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  output logic       load_use
);

  assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard / interrupt sequencing controller with a saturating stall counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       ex_rt,
  input  logic             ex_mem_read,
  input  logic             jump_id,
  input  logic             branch_taken_ex,
  input  logic             mem_busy,
  input  logic             irq,
  input  logic             pc31,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_bubble,
  output logic             epc_capture,
  output logic             exc_enter,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

  pipe_state_t        state, state_nxt;
  logic [DRAIN_W-1:0] drain_cnt, drain_nxt;
  logic               load_use;

  hazard_detect u_hazard (
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .load_use    (load_use)
  );

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    ex_mem_write  = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    epc_capture   = 1'b0;
    exc_enter     = 1'b0;
    state_nxt     = state;
    drain_nxt     = drain_cnt;
    // Reset overrides everything so outputs sit at RUN defaults while it is held.
    if (!reset) begin
      if (mem_busy) begin
        // Memory stall freezes every state; RUN parks in MEM_WAIT, others hold.
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        id_ex_write   = 1'b0;
        ex_mem_write  = 1'b0;
        mem_wb_bubble = 1'b1;
        if (state == ST_RUN) state_nxt = ST_MEM_WAIT;
      end else begin
        case (state)
          ST_RUN: begin
            if (branch_taken_ex) begin
              if_id_flush = 1'b1;
              id_ex_flush = 1'b1;
            end else if (irq && !pc31) begin
              epc_capture = 1'b1;
              if_id_flush = 1'b1;
              id_ex_flush = 1'b1;
              pc_write    = 1'b0;
              drain_nxt   = DRAIN_LOAD;
              state_nxt   = ST_IRQ_DRAIN;
            end else if (load_use) begin
              pc_write    = 1'b0;
              if_id_write = 1'b0;
              id_ex_flush = 1'b1;
            end else if (jump_id) begin
              if_id_flush = 1'b1;
            end
          end
          ST_MEM_WAIT: state_nxt = ST_RUN;
          ST_IRQ_DRAIN: begin
            pc_write    = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            // A count of 1 or 0 means this is the last drain cycle.
            if (drain_cnt <= DRAIN_W'(1)) begin
              drain_nxt = '0;
              state_nxt = ST_IRQ_ENTER;
            end else begin
              drain_nxt = drain_cnt - DRAIN_W'(1);
            end
          end
          ST_IRQ_ENTER: begin
            exc_enter   = 1'b1;
            if_id_flush = 1'b1;
            state_nxt   = ST_RUN;
          end
          default: state_nxt = ST_RUN;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
      if (!pc_write && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed + randomized check of pipe_ctrl against a cycle-level behavioural model.
module tb_pipe_ctrl;

  localparam int DRAIN = 2;
  localparam int CW    = 6;
  localparam int SAT   = (1 << CW) - 1;
  localparam logic [8:0] OUT_DEF    = 9'b1111_00000;
  localparam logic [8:0] OUT_FREEZE = 9'b0000_00100;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic ex_mem_read, jump_id, branch_taken_ex, mem_busy, irq, pc31;
  logic pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic if_id_flush, id_ex_flush, mem_wb_bubble, epc_capture, exc_enter;
  logic [CW-1:0] stall_cnt;

  pipe_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt),
    .ex_mem_read(ex_mem_read), .jump_id(jump_id), .branch_taken_ex(branch_taken_ex),
    .mem_busy(mem_busy), .irq(irq), .pc31(pc31), .pc_write(pc_write),
    .if_id_write(if_id_write), .id_ex_write(id_ex_write), .ex_mem_write(ex_mem_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_wb_bubble(mem_wb_bubble),
    .epc_capture(epc_capture), .exc_enter(exc_enter), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: a memory stall freezes anything; otherwise a pending wait-release,
  // remaining drain cycles, or a pending exception entry take precedence over RUN events.
  bit   m_wait, m_enter;
  int   m_drain, m_stall;
  logic [8:0] exp_out, last_out;
  int   exp_stall;
  logic [CW-1:0] last_stall;

  task automatic model_cycle();
    logic [8:0] o;
    bit lu;
    o = OUT_DEF;
    if (reset) begin
      m_wait = 0; m_enter = 0; m_drain = 0; m_stall = 0;
    end
    exp_stall = m_stall;
    lu = ex_mem_read && (ex_rt != 0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    if (!reset) begin
      if (mem_busy) begin
        o = OUT_FREEZE;
        if (m_drain == 0 && !m_enter) m_wait = 1;
      end else if (m_wait) begin
        m_wait = 0;
      end else if (m_drain > 0) begin
        o[8] = 0; o[4] = 1; o[3] = 1;
        m_drain--;
        if (m_drain == 0) m_enter = 1;
      end else if (m_enter) begin
        o[0] = 1; o[4] = 1;
        m_enter = 0;
      end else if (branch_taken_ex) begin
        o[4] = 1; o[3] = 1;
      end else if (irq && !pc31) begin
        o[1] = 1; o[4] = 1; o[3] = 1; o[8] = 0;
        m_drain = (DRAIN > 1) ? DRAIN - 1 : 1;
      end else if (lu) begin
        o[8] = 0; o[7] = 0; o[3] = 1;
      end else if (jump_id) begin
        o[4] = 1;
      end
      if (!o[8] && m_stall < SAT) m_stall++;
    end
    exp_out = o;
  endtask

  task automatic check(input string tag);
    logic [8:0] obs;
    obs = {pc_write, if_id_write, id_ex_write, ex_mem_write,
           if_id_flush, id_ex_flush, mem_wb_bubble, epc_capture, exc_enter};
    last_out   = obs;
    last_stall = stall_cnt;
    n_cmp++;
    assert (obs === exp_out) else begin
      n_fail++;
      $error("FAIL %s outputs: observed %b expected %b", tag, obs, exp_out);
    end
    n_cmp++;
    assert (stall_cnt === CW'(exp_stall)) else begin
      n_fail++;
      $error("FAIL %s stall_cnt: observed %0d expected %0d", tag, stall_cnt, exp_stall);
    end
  endtask

  task automatic spot(input string tag, input logic obs, input logic expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // Inputs are set 1 ns after a rising edge; checks happen on the falling edge.
  task automatic cycle(input string tag);
    #4;
    model_cycle();
    check(tag);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    id_rs = 5'd1; id_rt = 5'd2; ex_rt = 5'd3; ex_mem_read = 0; jump_id = 0;
    branch_taken_ex = 0; mem_busy = 0; irq = 0; pc31 = 0; reset = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    @(posedge clk); #1;
    cycle("reset_hold");
    reset = 1; ex_mem_read = 1; ex_rt = 5'd5; id_rs = 5'd5; mem_busy = 1; irq = 1;
    cycle("reset_ignores_inputs");
    idle();
    cycle("run_idle");

    ex_mem_read = 1; ex_rt = 5'd5; id_rs = 5'd5;
    cycle("load_use");
    spot("load_use_pc_write", last_out[8], 1'b0);
    spot("load_use_stall_before", last_stall[0], 1'b0);
    idle();
    cycle("after_load_use");
    spot("load_use_stall_after", last_stall[0], 1'b1);

    ex_mem_read = 1; ex_rt = 5'd0; id_rs = 5'd0;
    cycle("r0_no_stall");
    idle();

    ex_mem_read = 1; ex_rt = 5'd7; id_rt = 5'd7; jump_id = 1; branch_taken_ex = 1;
    cycle("branch_over_lu_jump");
    idle();
    jump_id = 1;
    cycle("jump_flush");
    idle();

    irq = 1;
    cycle("irq_accept");
    spot("irq_epc_t", last_out[1], 1'b1);
    irq = 0;
    cycle("irq_drain_t1");
    spot("irq_exc_t1", last_out[0], 1'b0);
    cycle("irq_enter_t2");
    spot("irq_exc_t2", last_out[0], 1'b1);
    cycle("irq_back_run");

    irq = 1;
    cycle("irq2_accept");
    irq = 0; mem_busy = 1;
    for (int i = 0; i < 3; i++) cycle("irq2_drain_busy");
    mem_busy = 0;
    cycle("irq2_drain_t4");
    spot("irq2_exc_t4", last_out[0], 1'b0);
    cycle("irq2_enter_t5");
    spot("irq2_exc_t5", last_out[0], 1'b1);
    idle();

    mem_busy = 1;
    for (int i = 0; i < 4; i++) cycle("mem_busy_freeze");
    mem_busy = 0;
    cycle("mem_wait_release");
    irq = 1; pc31 = 1;
    cycle("irq_masked");
    spot("irq_masked_epc", last_out[1], 1'b0);
    idle();

    irq = 1;
    cycle("irq3_accept");
    irq = 0;
    #2 reset = 1;
    #1;
    model_cycle();
    check("reset_mid_drain");
    @(posedge clk); #1;
    idle();
    cycle("after_reset_run");

    mem_busy = 1;
    for (int i = 0; i < SAT + 8; i++) cycle("saturate");
    spot("stall_saturated", &last_stall, 1'b1);
    idle();

    for (int i = 0; i < 1500; i++) begin
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      ex_rt = 5'($urandom_range(0, 3));
      ex_mem_read     = ($urandom_range(0, 1) == 1);
      jump_id         = ($urandom_range(0, 3) == 0);
      branch_taken_ex = ($urandom_range(0, 4) == 0);
      mem_busy        = ($urandom_range(0, 5) == 0);
      irq             = ($urandom_range(0, 7) == 0);
      pc31            = ($urandom_range(0, 2) == 0);
      reset           = ($urandom_range(0, 199) == 0);
      cycle("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
